// File: rtl/sct_serial_rx.sv
// Oversampling receiver for the serial control link. It takes a start bit, DATA_W data bits
// (LSB first), an optional even parity bit and one stop bit, and holds each received word
// in a one-entry valid/ready register.
module sct_serial_rx #(
   parameter int DATA_W    = 8,
   parameter int OVS       = 16,
   parameter int PARITY_EN = 1
) (
   input  logic              clk_pad,
   input  logic              rst_pad,
   input  logic              tick_pad,
   input  logic              sdi_pad,
   input  logic              rdy_pad,
   output logic              vld_pad,
   output logic [DATA_W-1:0] dat_pad,
   output logic              ferr_pad,
   output logic              perr_pad,
   output logic              ovr_pad,
   output logic              busy_pad
);

   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DATA_W) + 1;
   localparam logic [TW-1:0] MID_T  = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] FULL_T = TW'(OVS - 1);
   localparam logic [BW-1:0] LAST_B = BW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t              state_reg, state_next;
   logic                sync1_reg, sync2_reg;
   logic [TW-1:0]       tick_cnt_reg, tick_cnt_next;
   logic [BW-1:0]       bit_cnt_reg, bit_cnt_next;
   logic [DATA_W-1:0]   shift_reg, shift_next;
   logic                par_err_reg, par_err_next;
   logic                need_high_reg, need_high_next;
   logic                vld_reg, vld_next;
   logic [DATA_W-1:0]   dat_reg, dat_next;
   logic                ferr_reg, ferr_next;
   logic                perr_reg, perr_next;
   logic                ovr_reg, ovr_next;
   logic                load_req;
   logic                stop_err;
   logic                line;

   assign line = sync2_reg;

   // Synchroniser flops reset to the idle line level so reset never looks like a start edge.
   always_ff @(posedge clk_pad or posedge rst_pad) begin
      if (rst_pad) begin
         sync1_reg     <= 1'b1;
         sync2_reg     <= 1'b1;
         state_reg     <= IDLE;
         tick_cnt_reg  <= '0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         par_err_reg   <= 1'b0;
         need_high_reg <= 1'b0;
         vld_reg       <= 1'b0;
         dat_reg       <= '0;
         ferr_reg      <= 1'b0;
         perr_reg      <= 1'b0;
         ovr_reg       <= 1'b0;
      end else begin
         sync1_reg     <= sdi_pad;
         sync2_reg     <= sync1_reg;
         state_reg     <= state_next;
         tick_cnt_reg  <= tick_cnt_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         par_err_reg   <= par_err_next;
         need_high_reg <= need_high_next;
         vld_reg       <= vld_next;
         dat_reg       <= dat_next;
         ferr_reg      <= ferr_next;
         perr_reg      <= perr_next;
         ovr_reg       <= ovr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      tick_cnt_next  = tick_cnt_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      par_err_next   = par_err_reg;
      need_high_next = need_high_reg;
      vld_next       = vld_reg;
      dat_next       = dat_reg;
      ferr_next      = ferr_reg;
      perr_next      = perr_reg;
      ovr_next       = ovr_reg;
      load_req       = 1'b0;
      stop_err       = 1'b0;

      if (tick_pad) begin
         case (state_reg)
            IDLE: begin
               // After a low stop bit the line must go high before a new start is accepted.
               if (line) begin
                  need_high_next = 1'b0;
               end else if (!need_high_reg) begin
                  state_next    = START;
                  tick_cnt_next = '0;
               end
            end
            START: begin
               if (tick_cnt_reg == MID_T) begin
                  tick_cnt_next = '0;
                  bit_cnt_next  = '0;
                  par_err_next  = 1'b0;
                  state_next    = line ? IDLE : DATA;
               end else begin
                  tick_cnt_next = tick_cnt_reg + TW'(1);
               end
            end
            DATA: begin
               if (tick_cnt_reg == FULL_T) begin
                  tick_cnt_next             = '0;
                  shift_next                = shift_reg >> 1;
                  shift_next[DATA_W-1]      = line;
                  if (bit_cnt_reg == LAST_B) begin
                     bit_cnt_next = '0;
                     state_next   = (PARITY_EN != 0) ? PAR : STOP;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + BW'(1);
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + TW'(1);
               end
            end
            PAR: begin
               if (tick_cnt_reg == FULL_T) begin
                  tick_cnt_next = '0;
                  par_err_next  = (^shift_reg) ^ line;
                  state_next    = STOP;
               end else begin
                  tick_cnt_next = tick_cnt_reg + TW'(1);
               end
            end
            STOP: begin
               if (tick_cnt_reg == FULL_T) begin
                  tick_cnt_next  = '0;
                  stop_err       = ~line;
                  need_high_next = ~line;
                  load_req       = 1'b1;
                  state_next     = IDLE;
               end else begin
                  tick_cnt_next = tick_cnt_reg + TW'(1);
               end
            end
            default: begin
               state_next    = IDLE;
               tick_cnt_next = '0;
               bit_cnt_next  = '0;
            end
         endcase
      end

      // A load wins over a same-cycle transfer, so vld stays high across back-to-back words.
      if (load_req && (!vld_reg || rdy_pad)) begin
         vld_next  = 1'b1;
         dat_next  = shift_reg;
         ferr_next = stop_err;
         perr_next = par_err_reg;
      end else begin
         if (load_req) begin
            ovr_next = 1'b1;
         end
         if (vld_reg && rdy_pad) begin
            vld_next = 1'b0;
         end
      end
   end

   assign vld_pad  = vld_reg;
   assign dat_pad  = dat_reg;
   assign ferr_pad = ferr_reg;
   assign perr_pad = perr_reg;
   assign ovr_pad  = ovr_reg;
   assign busy_pad = (state_reg != IDLE);

endmodule

// File: tb/tb_sct_serial_rx.sv
// Scoreboard bench for sct_serial_rx. Stimulus pushes the expected words, and a negedge
// monitor pops and compares one expected word on every valid/ready transfer.
module tb_sct_serial_rx;

   localparam int DATA_W    = 8;
   localparam int OVS       = 16;
   localparam int PARITY_EN = 1;
   localparam int TDIV      = 4;
   localparam int BIT_CYC   = OVS * TDIV;

   logic              clk = 1'b0;
   logic              rst_pad;
   logic              tick_pad;
   logic              sdi_pad;
   logic              rdy_pad;
   logic              vld_pad;
   logic [DATA_W-1:0] dat_pad;
   logic              ferr_pad;
   logic              perr_pad;
   logic              ovr_pad;
   logic              busy_pad;

   sct_serial_rx #(.DATA_W(DATA_W), .OVS(OVS), .PARITY_EN(PARITY_EN)) dut (
      .clk_pad  (clk),
      .rst_pad  (rst_pad),
      .tick_pad (tick_pad),
      .sdi_pad  (sdi_pad),
      .rdy_pad  (rdy_pad),
      .vld_pad  (vld_pad),
      .dat_pad  (dat_pad),
      .ferr_pad (ferr_pad),
      .perr_pad (perr_pad),
      .ovr_pad  (ovr_pad),
      .busy_pad (busy_pad)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       p;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks      = 0;
   int   failures    = 0;
   int   cyc         = 0;
   int   frame_id    = 0;
   int   frame_start = 0;
   int   lat         = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // One tick pulse every TDIV cycles, phase locked to the cycle counter.
   initial begin
      tick_pad = 1'b0;
      forever begin
         @(posedge clk);
         #1 tick_pad = (cyc % TDIV == TDIV - 1);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic f, input logic p);
      sb_q.push_back('{d: d, f: f, p: p});
   endtask

   always @(negedge clk) begin
      if (!rst_pad && vld_pad && rdy_pad) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got dat 0x%0h expected no word", dat_pad);
         end else begin
            mon_e = sb_q.pop_front();
            $display("RX t=%0t dat=0x%0h ferr=%0b perr=%0b (want 0x%0h %0b %0b)",
                     $time, dat_pad, ferr_pad, perr_pad, mon_e.d, mon_e.f, mon_e.p);
            check("word_dat", dat_pad, mon_e.d);
            check("word_ferr", ferr_pad, mon_e.f);
            check("word_perr", perr_pad, mon_e.p);
         end
      end
   end

   task automatic align();
      @(posedge clk);
      #1;
      while (cyc % TDIV != 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_bit();
      repeat (BIT_CYC) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                             input int low_after);
      align();
      frame_start = cyc;
      frame_id++;
      sdi_pad = 1'b0;
      wait_bit();
      for (int i = 0; i < DATA_W; i++) begin
         sdi_pad = d[i];
         wait_bit();
      end
      sdi_pad = (^d) ^ par_flip;
      wait_bit();
      sdi_pad = stop_v;
      wait_bit();
      if (low_after > 0) begin
         sdi_pad = 1'b0;
         repeat (low_after) wait_bit();
      end
      sdi_pad = 1'b1;
      repeat (2) wait_bit();
   endtask

   // Measures cycles from frame start to the edge on which busy drops after the stop bit.
   task automatic calibrate();
      int id0 = frame_id;
      int n   = 0;
      wait (frame_id != id0);
      while (!busy_pad && n < 4 * BIT_CYC) begin
         @(posedge clk);
         #1;
         n++;
      end
      while (busy_pad && n < 20 * BIT_CYC) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy_pad || n >= 20 * BIT_CYC) begin
         checks++;
         failures++;
         $display("FAIL calib_timeout: got busy=%0b expected busy to fall within budget", busy_pad);
      end else begin
         lat = cyc - frame_start;
      end
   endtask

   // Raises rdy only in the cycle whose closing edge completes the stop bit.
   task automatic pulse_at_load();
      int id0 = frame_id;
      wait (frame_id != id0);
      if (lat < 2) begin
         checks++;
         failures++;
         $display("FAIL t5_latency: got %0d expected a measured frame latency", lat);
      end else begin
         while (cyc < frame_start + lat - 1) begin
            @(posedge clk);
            #1;
         end
         rdy_pad = 1'b1;
         @(posedge clk);
         #1;
         rdy_pad = 1'b0;
         check("t5_vld", vld_pad, 1);
         check("t5_dat", dat_pad, 8'h22);
         check("t5_ovr", ovr_pad, 0);
         check("t5_busy", busy_pad, 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_pad = 1'b1;
      sdi_pad = 1'b1;
      rdy_pad = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vld", vld_pad, 0);
      check("rst_dat", dat_pad, 0);
      check("rst_ferr", ferr_pad, 0);
      check("rst_perr", perr_pad, 0);
      check("rst_ovr", ovr_pad, 0);
      check("rst_busy", busy_pad, 0);
      rst_pad = 1'b0;
      wait_bit();

      // Clean frame, consumer always ready.
      push(8'hA5, 1'b0, 1'b0);
      fork
         send_frame(8'hA5, 1'b0, 1'b1, 0);
         calibrate();
      join
      check("t1_busy", busy_pad, 0);
      check("t1_vld", vld_pad, 0);
      check("t1_ovr", ovr_pad, 0);
      check("t1_lat_seen", (lat > 0), 1);

      // Parity error, then framing error with the line held low, then recovery.
      push(8'h3C, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1, 0);
      push(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 2);
      push(8'h01, 1'b0, 1'b0);
      send_frame(8'h01, 1'b0, 1'b1, 0);

      // Short low glitch: START is entered and abandoned without a word.
      align();
      sdi_pad = 1'b0;
      repeat (4 * TDIV) @(posedge clk);
      #1;
      check("t3_busy_in_glitch", busy_pad, 1);
      sdi_pad = 1'b1;
      repeat (2) wait_bit();
      check("t3_busy_after", busy_pad, 0);
      check("t3_vld_after", vld_pad, 0);
      push(8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b1, 0);

      // Overrun: second word dropped while the first is held.
      rdy_pad = 1'b0;
      push(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 0);
      check("t4_vld_held", vld_pad, 1);
      check("t4_dat_held", dat_pad, 8'h11);
      check("t4_ovr_set", ovr_pad, 1);
      rdy_pad = 1'b1;
      @(posedge clk);
      #1;
      rdy_pad = 1'b0;
      check("t4_vld_after", vld_pad, 0);
      check("t4_ovr_sticky", ovr_pad, 1);

      // Asynchronous reset in the middle of a 0xFF frame.
      rdy_pad = 1'b1;
      align();
      sdi_pad = 1'b0;
      wait_bit();
      sdi_pad = 1'b1;
      repeat (3) wait_bit();
      check("t6_busy_before", busy_pad, 1);
      rst_pad = 1'b1;
      #1;
      check("t6_vld", vld_pad, 0);
      check("t6_dat", dat_pad, 0);
      check("t6_ferr", ferr_pad, 0);
      check("t6_perr", perr_pad, 0);
      check("t6_ovr", ovr_pad, 0);
      check("t6_busy", busy_pad, 0);
      @(posedge clk);
      #1;
      rst_pad = 1'b0;
      repeat (2) wait_bit();
      push(8'h81, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, 0);

      // Ready in the exact load cycle: transfer and load together, no overrun.
      rdy_pad = 1'b0;
      push(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b0, 1'b1, 0);
      check("t5_vld_first", vld_pad, 1);
      push(8'h22, 1'b0, 1'b0);
      fork
         send_frame(8'h22, 1'b0, 1'b1, 0);
         pulse_at_load();
      join
      rdy_pad = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t5_drained", vld_pad, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sct_serial_rx.md
Name: sct_serial_rx

Overview:
- Serial-control receiver: the receive end of the serial control link whose transmit side is the existing combinational bit-counter/output-mux logic.
- Recovers frames from a single serial line: start bit, DATA_W data bits LSB-first, optional even parity, one stop bit.
- Oversamples each bit and presents each received word on a valid/ready interface with a one-word holding register.
- Reports framing, parity and overrun errors.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- OVS, 16, tick_pad pulses per bit period (even, 4..64).
- PARITY_EN, 1, 1 = even parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk_pad  in  1  clock, rising edge
- rst_pad  in  1  asynchronous reset, active-high
- tick_pad  in  1  oversample strobe, one-cycle pulse, OVS per bit
- sdi_pad  in  1  serial line; idles high
- rdy_pad  in  1  consumer ready
- vld_pad  out  1  holding register valid
- dat_pad  out  DATA_W  received word
- ferr_pad  out  1  stop bit sampled low for this word
- perr_pad  out  1  parity mismatch for this word
- ovr_pad  out  1  sticky overrun flag
- busy_pad  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, counters 0. Reset mid-frame discards the partial frame.
- sdi_pad passes through a 2-flop synchroniser before use, adding 2 cycles of input latency.
- All FSM and counter advances happen only on cycles with tick_pad=1, with one exception: the holding-register handshake runs every cycle.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: synchronised line low on a tick -> START, tick counter cleared.
- START: at tick count OVS/2-1 (mid-bit), resample the line.
  - Low -> DATA, counters cleared.
  - High -> IDLE. This is a glitch; no error is flagged.
- DATA: sample at each bit's mid-point (tick count OVS-1 counted from the mid-start point). Shift into a shift register LSB-first. Bit counter runs 0..DATA_W-1.
  - After the last bit: -> PAR if PARITY_EN, else -> STOP.
- PAR: sample at mid-bit. perr = (XOR of data bits) XOR sample.
- STOP: sample at mid-bit. ferr = ~sample. Then do the holding-register load below and go -> IDLE on the same tick.
  - If the stop bit is low, IDLE does not treat it as a new start edge until the line has been seen high at least once.
- Holding-register load, at the end of STOP:
  - vld_pad=0, or rdy_pad=1 in the same cycle: load dat/ferr/perr and set vld_pad=1.
  - Otherwise: drop the new word, keep the old one, set ovr_pad=1.
- Handshake: a transfer happens when vld_pad & rdy_pad. On the cycle after a transfer, vld_pad=0 unless a new load happened in the same cycle; load has priority, so vld stays 1.
- dat/ferr/perr hold stable while vld_pad=1.
- ovr_pad stays set until reset.
- Counter widths: tick counter clog2(OVS); bit counter clog2(DATA_W)+1. Both wrap-free: they are cleared on every state change.
- tick_pad high on consecutive cycles is legal; each pulse counts.
- Latency: vld_pad rises 1 cycle after the mid-stop-bit tick.

Test Plan (defaults unless noted):
- Send 0xA5 with parity 0 and stop 1, rdy_pad=1 -> one vld_pad pulse, dat_pad=0xA5, ferr=0, perr=0, ovr=0, busy_pad low after STOP.
- Send 0x3C with parity bit 1 -> dat_pad=0x3C, perr_pad=1. Then send 0x3C with stop bit low -> ferr_pad=1; the next frame 0x01 is received correctly only after the line returns high.
- Line low for 4 ticks then high (glitch) -> no vld_pad, FSM back to IDLE, busy_pad=0. A following 0x55 frame is received as 0x55.
- rdy_pad=0; send 0x11 then 0x22 -> vld_pad=1 with dat_pad=0x11 held and ovr_pad=1. Raise rdy_pad -> 0x11 transferred, vld_pad=0, ovr_pad remains 1.
- Assert rdy_pad in the exact cycle the second word completes while vld_pad=1 -> the first word is transferred, 0x22 is loaded, vld_pad stays 1, ovr_pad=0.
- Assert rst_pad mid-DATA of 0xFF -> all outputs 0 immediately (asynchronous). Release and send 0x81 -> dat_pad=0x81.
